// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   SEG_0..SEG_F : active-low glyphs, bit 0 = a ... bit 6 = g
//   SEG_BLANK    : all segments off
//   clog2w()     : counter width helper, never less than 1 bit
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bits needed to count 0..n-1 (n = number of states).
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display request inputs and pin outputs of the driver.
//   digits/dp/digit_en/blink/hex_mode/lz_blank : driven by the format logic
//   seg/dp_n/an                                : active-low board display pins
//   master : the side producing display requests
//   slave  : the scan driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    hex_mode;
    logic                    lz_blank;
    logic [6:0]              seg;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output digits, dp, digit_en, blink, hex_mode, lz_blank,
        input  seg, dp_n, an
    );

    modport slave (
        input  digits, dp, digit_en, blink, hex_mode, lz_blank,
        output seg, dp_n, an
    );
endinterface

// File: rtl/seg7_scan_driver_glyph_decode.sv
// seg7_glyph_decode: combinational 4-bit value to active-low 7-segment glyph.
//   value_i    : digit value 0..15
//   hex_mode_i : 1 = show A-F, 0 = BCD (values above 9 are blanked)
//   seg_o      : active-low segments, bit 6 = g
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       hex_mode_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        case (value_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
        if (!hex_mode_i && (value_i > 4'd9))
            seg_o = SEG_BLANK;
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment display driver.
//   clk   : system clock, rising edge
//   reset : synchronous, active high
//   bus   : slave side of seg7_scan_driver_if (display requests in, pins out)
// Each digit is lit for REFRESH_DIV cycles; blink toggles every BLINK_FRAMES
// frames. Requests are sampled once per frame (rcnt==0, idx==0) so a frame
// never mixes old and new values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                clk,
    input  logic                reset,
    seg7_scan_driver_if.slave   bus
);
    localparam int IDX_W = clog2w(NUM_DIGITS);
    localparam int RC_W  = clog2w(REFRESH_DIV);
    localparam int FC_W  = clog2w(BLINK_FRAMES);

    logic [RC_W-1:0]         rcnt_q, rcnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FC_W-1:0]         fcnt_q, fcnt_d;
    logic                    phase_q, phase_d;

    logic [4*NUM_DIGITS-1:0] sh_digits_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q, sh_blink_q;
    logic                    sh_hex_q, sh_lz_q;

    logic [6:0]              seg_q, seg_d;
    logic                    dpn_q, dpn_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    // Effective shadow: at frame start the live inputs are used directly so
    // the first slot of a frame already shows the freshly captured values.
    logic                    frame_start;
    logic [4*NUM_DIGITS-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]   eff_dp, eff_en, eff_blink;
    logic                    eff_hex, eff_lz;

    assign frame_start = (rcnt_q == '0) && (idx_q == '0);

    always_comb begin
        eff_digits = sh_digits_q;
        eff_dp     = sh_dp_q;
        eff_en     = sh_en_q;
        eff_blink  = sh_blink_q;
        eff_hex    = sh_hex_q;
        eff_lz     = sh_lz_q;
        if (frame_start) begin
            eff_digits = bus.digits;
            eff_dp     = bus.dp;
            eff_en     = bus.digit_en;
            eff_blink  = bus.blink;
            eff_hex    = bus.hex_mode;
            eff_lz     = bus.lz_blank;
        end
    end

    // Scan counters
    logic rcnt_wrap, idx_wrap;
    assign rcnt_wrap = (rcnt_q == RC_W'(REFRESH_DIV - 1));
    assign idx_wrap  = (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        rcnt_d  = rcnt_wrap ? '0 : rcnt_q + 1'b1;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (rcnt_wrap) begin
            if (idx_wrap) begin
                idx_d = '0;
                if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                    fcnt_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Leading-zero flags: digit i is blanked when it is zero and every
    // enabled digit above it is zero too; disabled digits do not count.
    logic [NUM_DIGITS-1:0] lz_zero;
    logic                  upper_zero;

    always_comb begin
        lz_zero    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_zero[i] = eff_lz && (i != 0) && upper_zero &&
                         (eff_digits[4*i +: 4] == 4'h0);
            if (eff_en[i] && (eff_digits[4*i +: 4] != 4'h0))
                upper_zero = 1'b0;
        end
    end

    // Select the current digit
    logic [3:0] sel_val;
    logic       sel_dp, sel_en, sel_blink, sel_lz;

    always_comb begin
        sel_val   = '0;
        sel_dp    = 1'b0;
        sel_en    = 1'b0;
        sel_blink = 1'b0;
        sel_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_val   = eff_digits[4*i +: 4];
                sel_dp    = eff_dp[i];
                sel_en    = eff_en[i];
                sel_blink = eff_blink[i];
                sel_lz    = lz_zero[i];
            end
        end
    end

    logic [6:0] glyph;

    seg7_glyph_decode u_dec (
        .value_i    (sel_val),
        .hex_mode_i (eff_hex),
        .seg_o      (glyph)
    );

    logic visible;
    assign visible = sel_en && (!sel_blink || phase_q) && !sel_lz;

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dpn_d = 1'b1;
        if (visible) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = glyph;
            dpn_d = ~sel_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q      <= '0;
            idx_q       <= '0;
            fcnt_q      <= '0;
            phase_q     <= 1'b1;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '0;
            sh_blink_q  <= '0;
            sh_hex_q    <= 1'b0;
            sh_lz_q     <= 1'b0;
            seg_q       <= SEG_BLANK;
            dpn_q       <= 1'b1;
            an_q        <= '1;
        end else begin
            rcnt_q      <= rcnt_d;
            idx_q       <= idx_d;
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
            sh_digits_q <= eff_digits;
            sh_dp_q     <= eff_dp;
            sh_en_q     <= eff_en;
            sh_blink_q  <= eff_blink;
            sh_hex_q    <= eff_hex;
            sh_lz_q     <= eff_lz;
            seg_q       <= seg_d;
            dpn_q       <= dpn_d;
            an_q        <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.dp_n = dpn_q;
    assign bus.an   = an_q;

endmodule
